// File: rtl/iob_regarray_2p_reader_if.sv
// Stream interface carrying register words out of the register-array reader.
// The master drives valid/data/last; the slave answers with ready.
interface iob_regarray_2p_reader_if #(
    parameter int DATA_W = 32
);
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              last;
    logic              ready;

    modport master (
        output valid,
        output data,
        output last,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  last,
        output ready
    );
endinterface

// File: rtl/iob_regarray_2p_reader.sv
// Read-side engine for the two-port register array.
// Walks base..base+len-1 (wrapping N-1 -> 0) over the combinational read port
// and emits each word on a valid/ready stream, marking the final word with last.
// Clock enable low freezes every flop; the synchronous active-low reset wins
// over the clock enable so a frozen block can still be brought back to IDLE.
module iob_regarray_2p_reader #(
    parameter int N      = 8,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3,
    parameter int LEN_W  = 4
) (
    input  logic              clk_i,
    input  logic              cke_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] raddr_o,
    input  logic [DATA_W-1:0] rdata_i,
    iob_regarray_2p_reader_if.master m
);

    // Array size widened by one bit so "index < N" is never a constant compare.
    localparam logic [ADDR_W:0]   N_EXT    = (ADDR_W+1)'(N);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);
    localparam logic [ADDR_W-1:0] IDX_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
    localparam logic [LEN_W-1:0]  REM_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0]  REM_ONE  = LEN_W'(1);
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Next read index, wrapping from the last register back to register 0.
    function automatic logic [ADDR_W-1:0] next_idx(input logic [ADDR_W-1:0] idx);
        logic [ADDR_W-1:0] nxt;
        if (idx == LAST_IDX) begin
            nxt = IDX_ZERO;
        end else begin
            nxt = idx + IDX_ONE;
        end
        return nxt;
    endfunction

    // A base index outside the array restarts the walk at register 0.
    function automatic logic [ADDR_W-1:0] clamp_base(input logic [ADDR_W-1:0] idx);
        logic [ADDR_W-1:0] res;
        if ({1'b0, idx} < N_EXT) begin
            res = idx;
        end else begin
            res = IDX_ZERO;
        end
        return res;
    endfunction

    state_t            state_q, state_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [LEN_W-1:0]  rem_q,   rem_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic              last_q,  last_d;
    logic              load_s;

    // Output register may take a new word when empty or when its word leaves.
    assign load_s = !valid_q || m.ready;

    // Next-state and next-output computation for the transfer FSM.
    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        raddr_d = raddr_q;
        rem_d   = rem_q;
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (len_i != REM_ZERO) begin
                        state_d = ST_RUN;
                        raddr_d = clamp_base(base_i);
                        rem_d   = len_i;
                        busy_d  = 1'b1;
                    end else begin
                        // Empty transfer: report completion without any beat.
                        done_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_RUN: begin
                if (load_s) begin
                    // Handshake of the old word and load of the new one share a cycle.
                    data_d  = rdata_i;
                    valid_d = 1'b1;
                    last_d  = (rem_q == REM_ONE);
                    rem_d   = rem_q - REM_ONE;
                    raddr_d = next_idx(raddr_q);
                    if (rem_q == REM_ONE) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end

            ST_DRAIN: begin
                if (valid_q && m.ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                valid_d = 1'b0;
                last_d  = 1'b0;
                rem_d   = REM_ZERO;
            end
        endcase
    end

    // State and output registers: reset first, then update only on clock enable.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            raddr_q <= IDX_ZERO;
            rem_q   <= REM_ZERO;
            valid_q <= 1'b0;
            data_q  <= DATA_ZERO;
            last_q  <= 1'b0;
        end else if (cke_i) begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            raddr_q <= raddr_d;
            rem_q   <= rem_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end else begin
            state_q <= state_q;
            busy_q  <= busy_q;
            done_q  <= done_q;
            raddr_q <= raddr_q;
            rem_q   <= rem_q;
            valid_q <= valid_q;
            data_q  <= data_q;
            last_q  <= last_q;
        end
    end

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign raddr_o = raddr_q;
    assign m.valid = valid_q;
    assign m.data  = data_q;
    assign m.last  = last_q;

endmodule

// File: tb/tb_iob_regarray_2p_reader.sv
// Directed and randomized bench for iob_regarray_2p_reader.
// The reference model is a queue of expected words built from the register
// contents with modulo-N index arithmetic; each accepted beat pops one word.
module tb_iob_regarray_2p_reader;

    localparam int N      = 8;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 3;
    localparam int LEN_W  = 4;

    logic              clk = 1'b0;
    logic              cke;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] regs [N];

    int n_tests = 0;
    int n_fail  = 0;

    iob_regarray_2p_reader_if #(.DATA_W(DATA_W)) m_if ();

    // Combinational register-array read port.
    assign rdata = regs[raddr];

    iob_regarray_2p_reader #(
        .N(N), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)
    ) dut (
        .clk_i   (clk),
        .cke_i   (cke),
        .rst_n_i (rst_n),
        .start_i (start),
        .base_i  (base),
        .len_i   (len),
        .busy_o  (busy),
        .done_o  (done),
        .raddr_o (raddr),
        .rdata_i (rdata),
        .m       (m_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_regs_pattern();
        for (int i = 0; i < N; i++) regs[i] = 32'hA0 + 32'(i);
    endtask

    task automatic set_regs_random();
        for (int i = 0; i < N; i++) regs[i] = $urandom;
    endtask

    // rmode: 0 ready always high, 1 ready toggles 1,0,1,0..., 2 random ready.
    // stall_at: cycle at which cke drops for 3 cycles (-1 none).
    // restart_at: cycle at which a start pulse is issued while busy (-1 none).
    task automatic burst(input string name, input int b, input int l,
                         input int rmode, input int stall_at, input int restart_at);
        logic [DATA_W-1:0] exp_q[$];
        logic [DATA_W-1:0] hold_d, frz_d;
        logic              hold_l, frz_v, frz_b;
        logic [ADDR_W-1:0] frz_a;
        bit                hold_chk, xfer, fin;
        int                c;

        for (int k = 0; k < l; k++) exp_q.push_back(regs[(b + k) % N]);

        start = 1'b1; base = ADDR_W'(b); len = LEN_W'(l); cke = 1'b1; m_if.ready = 1'b1;
        step();
        start = 1'b0;
        chk({name, " busy_after_start"}, busy, 1);
        chk({name, " valid_after_start"}, m_if.valid, 0);
        chk({name, " raddr_base"}, raddr, b);

        c = 0; fin = 0;
        while (!fin && c < 300) begin
            cke = !(stall_at >= 0 && c >= stall_at && c < stall_at + 3);
            case (rmode)
                0: m_if.ready = 1'b1;
                1: m_if.ready = (c % 2 == 0);
                default: m_if.ready = ($urandom_range(0, 3) != 0);
            endcase
            start = (c == restart_at);
            if (start) begin
                base = ADDR_W'($urandom_range(0, N - 1));
                len  = LEN_W'($urandom_range(1, 15));
            end
            chk({name, " done_low_in_burst"}, done, 0);
            frz_v = m_if.valid; frz_d = m_if.data; frz_a = raddr; frz_b = busy;
            xfer = m_if.valid && m_if.ready && cke;
            if (xfer) begin
                if (exp_q.size() == 0) begin
                    chk({name, " extra_beat"}, 1, 0);
                end else begin
                    chk({name, " data"}, m_if.data, exp_q[0]);
                    chk({name, " last"}, m_if.last, (exp_q.size() == 1));
                    void'(exp_q.pop_front());
                end
            end
            hold_chk = m_if.valid && !m_if.ready && cke;
            hold_d = m_if.data; hold_l = m_if.last;
            step();
            c++;
            start = 1'b0;
            if (!cke) begin
                chk({name, " frozen_valid"}, m_if.valid, frz_v);
                chk({name, " frozen_data"}, m_if.data, frz_d);
                chk({name, " frozen_raddr"}, raddr, frz_a);
                chk({name, " frozen_busy"}, busy, frz_b);
            end
            if (hold_chk) begin
                chk({name, " hold_valid"}, m_if.valid, 1);
                chk({name, " hold_data"}, m_if.data, hold_d);
                chk({name, " hold_last"}, m_if.last, hold_l);
            end
            if (xfer && exp_q.size() == 0) begin
                fin = 1;
                chk({name, " done_pulse"}, done, 1);
                chk({name, " busy_end"}, busy, 0);
                chk({name, " valid_end"}, m_if.valid, 0);
                chk({name, " last_end"}, m_if.last, 0);
                if (rmode == 0 && stall_at < 0) chk({name, " cycles"}, c, l + 1);
            end
        end
        chk({name, " finished"}, fin, 1);
        cke = 1'b1; m_if.ready = 1'b1;
        step();
        chk({name, " done_one_cycle"}, done, 0);
        chk({name, " idle_valid"}, m_if.valid, 0);
        chk({name, " idle_busy"}, busy, 0);
    endtask

    initial begin
        rst_n = 1'b0; cke = 1'b0; start = 1'b0; base = '0; len = '0;
        m_if.ready = 1'b1;
        set_regs_pattern();

        // Reset applies even with clock enable low.
        step(); step();
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst valid", m_if.valid, 0);
        chk("rst last", m_if.last, 0);
        chk("rst data", m_if.data, 0);
        chk("rst raddr", raddr, 0);
        cke = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst busy", busy, 0);
        chk("post_rst valid", m_if.valid, 0);

        // Plain burst at full throughput.
        burst("burst", 2, 4, 0, -1, -1);

        // Wrap-around with alternating backpressure.
        burst("wrap", 6, 4, 1, -1, -1);

        // Zero-length start.
        start = 1'b1; base = 3'd3; len = 4'd0;
        step();
        start = 1'b0;
        chk("len0 done", done, 1);
        chk("len0 busy", busy, 0);
        chk("len0 valid", m_if.valid, 0);
        step();
        chk("len0 done_cleared", done, 0);
        chk("len0 no_valid", m_if.valid, 0);

        // Start pulse while busy must be ignored.
        burst("restart", 1, 6, 0, -1, 3);

        // Reset in the middle of a len=5 burst.
        start = 1'b1; base = 3'd1; len = 4'd5; m_if.ready = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("abort beat1", m_if.data, regs[1]);
        step();
        chk("abort beat2", m_if.data, regs[2]);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("abort valid", m_if.valid, 0);
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort raddr", raddr, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("abort no_done", done, 0);
            chk("abort no_valid", m_if.valid, 0);
        end
        burst("after_abort", 5, 5, 0, -1, -1);

        // Clock enable low for 3 cycles mid-burst.
        burst("cke_stall", 0, 6, 0, 3, -1);
        burst("cke_stall_bp", 4, 7, 1, 2, -1);

        // Randomized bursts against random register contents.
        for (int t = 0; t < 20; t++) begin
            int rb, rl, rs, rr;
            set_regs_random();
            rb = $urandom_range(0, N - 1);
            rl = $urandom_range(1, 15);
            rs = ($urandom_range(0, 1) == 1) ? $urandom_range(0, rl) : -1;
            rr = ($urandom_range(0, 1) == 1) ? $urandom_range(1, rl) : -1;
            burst("random", rb, rl, 2, rs, rr);
        end

        // Maximum length wraps around the array more than once.
        set_regs_random();
        burst("max_len", 7, 15, 0, -1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
